// File: rtl/kf_mac_arbiter_if.sv
// Request/grant/completion bundle between the requesters
// and the shared matrix MAC arbiter.
interface kf_mac_arbiter_if;
  logic       en;
  logic [3:0] req;
  logic       mac_done;
  logic [3:0] gnt;
  logic       mac_start;
  logic [1:0] mac_sel;
  logic [3:0] done;
  logic       err;
  logic       busy;

  modport master (
    output en, req, mac_done,
    input  gnt, mac_start, mac_sel,
    input  done, err, busy
  );

  modport slave (
    input  en, req, mac_done,
    output gnt, mac_start, mac_sel,
    output done, err, busy
  );
endinterface

// File: rtl/kf_mac_arbiter.sv
// Round-robin arbiter for the shared matrix MAC engine:
// one job at a time, done routing and watchdog abort.
module kf_mac_arbiter #(
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input logic             clk,
  input logic             rst_n,
  kf_mac_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RELEASE
  } state_t;

  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  state_t        state;
  logic [TW-1:0] wd;
  logic [1:0]    ptr;
  logic [1:0]    pick;
  logic          hit;

  // search ptr+1, ptr+2, ptr+3, then ptr itself
  always_comb begin
    pick = ptr;
    hit  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!hit && bus.req[ptr + 2'(k)]) begin
        pick = ptr + 2'(k);
        hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.gnt       <= '0;
      bus.mac_start <= 1'b0;
      bus.mac_sel   <= '0;
      bus.done      <= '0;
      bus.err       <= 1'b0;
      bus.busy      <= 1'b0;
      wd            <= '0;
      ptr           <= 2'd3;
    end else begin
      bus.mac_start <= 1'b0;
      bus.done      <= '0;
      bus.err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.en && hit) begin
            state         <= ISSUE;
            bus.gnt       <= 4'b0001 << pick;
            bus.mac_sel   <= pick;
            bus.mac_start <= 1'b1;
            bus.busy      <= 1'b1;
            wd            <= '0;
          end
        end
        ISSUE: begin
          state <= WAIT;
          wd    <= (&wd) ? wd : wd + 1'b1;
        end
        WAIT: begin
          // a completion in the timeout cycle still wins
          if (bus.mac_done) begin
            state    <= RELEASE;
            bus.done <= bus.gnt;
            bus.gnt  <= '0;
            ptr      <= bus.mac_sel;
          end else if (wd >= TMO) begin
            state   <= RELEASE;
            bus.err <= 1'b1;
            bus.gnt <= '0;
            ptr     <= bus.mac_sel;
          end else begin
            wd <= (&wd) ? wd : wd + 1'b1;
          end
        end
        RELEASE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_kf_mac_arbiter.sv
// Directed table-driven bench for kf_mac_arbiter
// (instantiated with TIMEOUT=8).
module tb_kf_mac_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic mon_on = 1'b0;

  always #5 clk = ~clk;

  kf_mac_arbiter_if bus();

  kf_mac_arbiter #(
    .TIMEOUT(8),
    .TW     (10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic        md;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input string tag, input int rst, input int en,
    input int req, input int md, input int gnt,
    input int ms, input int sel, input int done,
    input int err, input int busy
  );
    vec_t v;
    v.tag = tag;
    v.rst = 1'(rst);
    v.en  = 1'(en);
    v.req = 4'(req);
    v.md  = 1'(md);
    v.exp = {4'(gnt), 1'(ms), 2'(sel),
             4'(done), 1'(err), 1'(busy)};
    tbl.push_back(v);
  endtask

  function automatic logic [12:0] act();
    return {bus.gnt, bus.mac_start, bus.mac_sel,
            bus.done, bus.err, bus.busy};
  endfunction

  task automatic chk(input string name,
                     input logic [12:0] a,
                     input logic [12:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got gnt=%b start=%b sel=%0d done=%b err=%b busy=%b, want gnt=%b start=%b sel=%0d done=%b err=%b busy=%b",
               name, a[12:9], a[8], a[7:6], a[5:2], a[1], a[0],
               e[12:9], e[8], e[7:6], e[5:2], e[1], e[0]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      if (!$onehot0(bus.gnt) || (|bus.done && bus.err)) begin
        errors++;
        $display("FAIL invariant: gnt=%b done=%b err=%b, want gnt zero/one-hot and not done&err",
                 bus.gnt, bus.done, bus.err);
      end
    end
  end

  initial begin
    // tag, rst, en, req, md | gnt, start, sel, done, err, busy
    add("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("a_grant", 0, 1, 'b0001, 0, 'b0001, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      add("a_wait", 0, 1, 'b0001, 0, 'b0001, 0, 0, 0, 0, 1);
    add("a_done", 0, 1, 'b0001, 1, 0, 0, 0, 'b0001, 0, 1);
    add("a_idle", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add("a_ign", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);

    add("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 5; j++) begin
      int idx;
      int oh;
      idx = j % 4;
      oh  = 1 << idx;
      add("b_grant", 0, 1, 'hf, 0, oh, 1, idx, 0, 0, 1);
      add("b_wait", 0, 1, 'hf, 0, oh, 0, idx, 0, 0, 1);
      add("b_wait", 0, 1, 'hf, 0, oh, 0, idx, 0, 0, 1);
      add("b_done", 0, 1, 'hf, 1, 0, 0, idx, oh, 0, 1);
      add("b_rel", 0, 1, 'hf, 1, 0, 0, idx, 0, 0, 0);
    end

    add("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("c_grant", 0, 1, 'b0100, 0, 'b0100, 1, 2, 0, 0, 1);
    for (int i = 0; i < 8; i++)
      add("c_wait", 0, 1, 'b0100, 0, 'b0100, 0, 2, 0, 0, 1);
    add("c_err", 0, 1, 'b0100, 0, 0, 0, 2, 0, 1, 1);
    add("c_rel", 0, 1, 'b1101, 0, 0, 0, 2, 0, 0, 0);
    add("c_next", 0, 1, 'b1101, 0, 'b1000, 1, 3, 0, 0, 1);
    add("c_w", 0, 1, 'b1101, 0, 'b1000, 0, 3, 0, 0, 1);
    add("c_done", 0, 1, 'b0101, 1, 0, 0, 3, 'b1000, 0, 1);
    add("c_idle", 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);

    add("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("d_grant", 0, 1, 'b0001, 0, 'b0001, 1, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++)
      add("d_wait", 0, 1, 'b0001, 0, 'b0001, 0, 0, 0, 0, 1);
    add("d_tie", 0, 1, 'b0001, 1, 0, 0, 0, 'b0001, 0, 1);
    add("d_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    add("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("e_off", 0, 0, 'b0010, 0, 0, 0, 0, 0, 0, 0);
    add("e_off", 0, 0, 'b0010, 0, 0, 0, 0, 0, 0, 0);
    add("e_on", 0, 1, 'b0010, 0, 'b0010, 1, 1, 0, 0, 1);
    add("e_enlow", 0, 0, 'b0010, 0, 'b0010, 0, 1, 0, 0, 1);
    add("e_reqlow", 0, 0, 0, 0, 'b0010, 0, 1, 0, 0, 1);
    add("e_wait", 0, 0, 0, 0, 'b0010, 0, 1, 0, 0, 1);
    add("e_done", 0, 0, 0, 1, 0, 0, 1, 'b0010, 0, 1);
    add("e_idle", 0, 0, 'b0010, 0, 0, 0, 1, 0, 0, 0);
    add("e_blk", 0, 0, 'b0010, 0, 0, 0, 1, 0, 0, 0);
    add("e_again", 0, 1, 'b0010, 0, 'b0010, 1, 1, 0, 0, 1);
    add("e_w2", 0, 1, 'b0010, 0, 'b0010, 0, 1, 0, 0, 1);
    add("e_d2", 0, 1, 0, 1, 0, 0, 1, 'b0010, 0, 1);
    add("e_i2", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);

    add("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("f_g0", 0, 1, 'b0011, 0, 'b0001, 1, 0, 0, 0, 1);
    add("f_w0", 0, 1, 'b0011, 0, 'b0001, 0, 0, 0, 0, 1);
    add("f_d0", 0, 1, 'b0011, 1, 0, 0, 0, 'b0001, 0, 1);
    add("f_r0", 0, 1, 'b0010, 0, 0, 0, 0, 0, 0, 0);
    add("f_g1", 0, 1, 'b0010, 0, 'b0010, 1, 1, 0, 0, 1);
    add("f_w1", 0, 1, 'b0010, 0, 'b0010, 0, 1, 0, 0, 1);
    add("f_d1", 0, 1, 0, 1, 0, 0, 1, 'b0010, 0, 1);
    add("f_i1", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);

    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.req      = '0;
    bus.mac_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b1;

    foreach (tbl[i]) begin
      rst_n        = !tbl[i].rst;
      bus.en       = tbl[i].en;
      bus.req      = tbl[i].req;
      bus.mac_done = tbl[i].md;
      @(posedge clk);
      #1;
      chk(tbl[i].tag, act(), tbl[i].exp);
    end

    // asynchronous reset in the middle of a job
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.en       = 1'b1;
    bus.req      = 4'b0001;
    bus.mac_done = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("g_wait", act(), {4'b0001, 1'b0, 2'd0, 4'b0, 1'b0, 1'b1});
    #3;
    rst_n = 1'b0;
    #1;
    chk("g_async", act(), 13'd0);
    @(posedge clk);
    #1;
    chk("g_held", act(), 13'd0);
    rst_n   = 1'b1;
    bus.req = 4'b1001;
    @(posedge clk);
    #1;
    chk("g_prio", act(), {4'b0001, 1'b1, 2'd0, 4'b0, 1'b0, 1'b1});

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
